// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation encoding used by both
// ALU control and EX, plus datapath constants and small helpers.
package ex_stage_pkg;

   localparam int DW  = 32;
   localparam int SHW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDU = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SUBU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_SLT  = 4'd11,
      ALU_SLTU = 4'd12
   } alu_op_e;

   // Signed overflow of a two's-complement add/sub, judged on the sign bits only.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb != b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/ex_stage_alu_core.sv
// Purely combinational ALU: (a, b, shift amount, op) -> (result, signed overflow).
module ex_stage_alu_core
   import ex_stage_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0]  a_i,
   input  logic [DW-1:0]  b_i,
   input  logic [SHW-1:0] s_i,
   input  logic [3:0]     aluc_i,
   output logic [DW-1:0]  result_o,
   output logic           ovf_o
);

   logic [DW-1:0] sum;
   logic [DW-1:0] diff;
   logic          slt_s;
   logic          slt_u;

   assign sum   = a_i + b_i;
   assign diff  = a_i - b_i;
   assign slt_s = $signed(a_i) < $signed(b_i);
   assign slt_u = a_i < b_i;

   // Operation select; unknown codes yield zero so a bad decode cannot leak operands.
   always_comb begin
      result_o = {DW{1'b0}};
      ovf_o    = 1'b0;
      case (aluc_i)
         ALU_ADD: begin
            result_o = sum;
            ovf_o    = add_ovf(a_i[DW-1], b_i[DW-1], sum[DW-1]);
         end
         ALU_ADDU: result_o = sum;
         ALU_SUB: begin
            result_o = diff;
            ovf_o    = sub_ovf(a_i[DW-1], b_i[DW-1], diff[DW-1]);
         end
         ALU_SUBU: result_o = diff;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_NOR:  result_o = ~(a_i | b_i);
         ALU_SLL:  result_o = b_i << s_i;
         ALU_SRL:  result_o = b_i >> s_i;
         ALU_SRA:  result_o = DW'($signed(b_i) >>> s_i);
         ALU_SLT:  result_o = {{(DW-1){1'b0}}, slt_s};
         ALU_SLTU: result_o = {{(DW-1){1'b0}}, slt_u};
         default: begin
            result_o = {DW{1'b0}};
            ovf_o    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: valid/ready handshake, flush and the EX/MEM output register
// around the combinational ALU core.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_aluc,
   input  logic [DW-1:0]   in_a,
   input  logic [DW-1:0]   in_b,
   input  logic [SHW-1:0]  in_shamt,
   input  logic            in_use_shamt,
   input  logic            in_wreg,
   input  logic [4:0]      in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_result,
   output logic            out_zero,
   output logic            out_ovf,
   output logic            out_wreg,
   output logic [4:0]      out_rd
);

   logic [SHW-1:0] shift_amt;
   logic [DW-1:0]  alu_result;
   logic           alu_ovf;
   logic           accept;
   logic           xfer_out;

   logic           valid_q,  valid_d;
   logic [DW-1:0]  result_q, result_d;
   logic           zero_q,   zero_d;
   logic           ovf_q,    ovf_d;
   logic           wreg_q,   wreg_d;
   logic [4:0]     rd_q,     rd_d;

   assign shift_amt = in_use_shamt ? in_shamt : in_a[SHW-1:0];

   ex_stage_alu_core #(.DW(DW)) u_alu (
      .a_i      (in_a),
      .b_i      (in_b),
      .s_i      (shift_amt),
      .aluc_i   (in_aluc),
      .result_o (alu_result),
      .ovf_o    (alu_ovf)
   );

   // An empty register or one draining this cycle can take a new instruction.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer_out = valid_q && out_ready;

   // EX/MEM next state: flush beats accept beats drain; otherwise stall.
   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      wreg_d   = wreg_q;
      rd_d     = rd_q;
      if (flush) begin
         valid_d = 1'b0;
         wreg_d  = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         result_d = alu_result;
         zero_d   = (alu_result == {DW{1'b0}});
         ovf_d    = alu_ovf;
         // An overflowing ADD/SUB must not write back.
         wreg_d   = in_wreg && !alu_ovf;
         rd_d     = in_rd;
      end else if (xfer_out) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // EX/MEM register; reset drops any held instruction immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= {DW{1'b0}};
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wreg_q   <= 1'b0;
         rd_q     <= 5'd0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         wreg_q   <= wreg_d;
         rd_q     <= rd_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_zero   = zero_q;
   assign out_ovf    = ovf_q;
   assign out_wreg   = wreg_q;
   assign out_rd     = rd_q;

endmodule
